// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU arbiter slice.
//   DATA_W_DEFAULT : default operand/result width
//   OP_*           : ALU control codes
//   state_t        : arbiter FSM state type (legacy 2-bit encoding kept)
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    RESP = ST_RESP
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational ALU datapath.
//   a, b   : signed operands (DATA_W)
//   op     : control code (see alu_pkg OP_*); undefined codes give 0
//   result : DATA_W result, add/sub wrap modulo 2^DATA_W
//   zero   : high when result is all zeros
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  logic slt;

  always_comb begin
    slt    = ($signed(a) < $signed(b));
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin grant and
// a three-state FSM (IDLE -> EXEC -> RESP). One operation in flight.
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid/ready           : request handshake (ready only in IDLE, winner only)
//   reqN_a, reqN_b, reqN_op    : operands and ALU code
//   rspN_valid/ready           : response handshake, held until taken
//   rspN_result, rspN_zero     : registered result and zero flag
//   busy                       : FSM not IDLE
//   op_count                   : completed response handshakes (wraps)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  logic              rr_ptr;   // 0: favour requester 0 on contention
  logic              winner;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              grant0;
  logic              grant1;
  logic              rsp_done;

  // A lone valid always wins; the pointer only breaks ties.
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || !rr_ptr);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid ||  rr_ptr);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);
  assign rsp_done   = winner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);

  alu_arbiter_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      winner      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            winner <= grant1;
            a_q    <= grant1 ? req1_a  : req0_a;
            b_q    <= grant1 ? req1_b  : req0_b;
            op_q   <= grant1 ? req1_op : req0_op;
            // Pointer moves only after contention, so a lone requester
            // does not steal the other's next turn.
            if (req0_valid && req1_valid) begin
              rr_ptr <= grant0;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          if (winner) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
          end else begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            if (winner) begin
              rsp1_valid <= 1'b0;
            end else begin
              rsp0_valid <= 1'b0;
            end
            op_count <= op_count + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter (CNT_W=4).
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          rsp0_zero, rsp1_zero, busy;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .busy        (busy),
    .op_count    (op_count)
  );

  typedef struct {
    bit            id;
    logic [DW-1:0] res;
    logic          z;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  logic [CW-1:0] exp_cnt;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return DW'(0);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input bit id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [2:0] op);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Waits for the grant of requester id, records the expected response and
  // checks the T+1 / T+2 response timing. Returns at the negedge of T+2.
  task automatic accept(input bit id, input string tag, output int waited);
    bit   ok;
    exp_t e;
    ok     = 1'b0;
    waited = 0;
    #1;
    while (waited < 20) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    check({tag, " grant"}, 64'(ok), 64'd1);
    if (!ok) return;
    check({tag, " other_ready"}, 64'(id ? req0_ready : req1_ready), 64'd0);
    e.id  = id;
    e.res = id ? model(req1_a, req1_b, req1_op) : model(req0_a, req0_b, req0_op);
    e.z   = (e.res == '0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    @(negedge clk);
    check({tag, " exec_busy"}, 64'(busy), 64'd1);
    check({tag, " exec_rsp_low"}, 64'(id ? rsp1_valid : rsp0_valid), 64'd0);
    check({tag, " exec_ready_low"}, 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    check({tag, " t2_rsp_valid"}, 64'(id ? rsp1_valid : rsp0_valid), 64'd1);
  endtask

  // Holds rsp_ready low for `hold` cycles, checking response stability, then
  // completes the handshake. Returns at posedge+1 after the handshake.
  task automatic collect(input int hold, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, " scoreboard_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check({tag, " rsp_valid"}, 64'(e.id ? rsp1_valid : rsp0_valid), 64'd1);
      check({tag, " result"}, 64'(e.id ? rsp1_result : rsp0_result), 64'(e.res));
      check({tag, " zero"}, 64'(e.id ? rsp1_zero : rsp0_zero), 64'(e.z));
      check({tag, " other_rsp_low"}, 64'(e.id ? rsp0_valid : rsp1_valid), 64'd0);
      check({tag, " req_ready_low"}, 64'({req0_ready, req1_ready}), 64'd0);
      check({tag, " busy"}, 64'(busy), 64'd1);
      if (i < hold) @(negedge clk);
    end
    if (e.id == 1'b0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_cnt++;
    check({tag, " rsp_cleared"}, 64'(e.id ? rsp1_valid : rsp0_valid), 64'd0);
    check({tag, " op_count"}, 64'(op_count), 64'(exp_cnt));
    check({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    exp_cnt = '0;

    // Reset state
    #12;
    check("rst busy", 64'(busy), 64'd0);
    check("rst rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    check("rst results", 64'(rsp0_result | rsp1_result), 64'd0);
    check("rst zero", 64'({rsp0_zero, rsp1_zero}), 64'd0);
    check("rst op_count", 64'(op_count), 64'd0);
    check("rst req_ready", 64'({req0_ready, req1_ready}), 64'd0);

    // Single req0 sub 7-5, granted on first edge after release
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(1'b0, 32'd7, 32'd5, OP_SUB);
    accept(1'b0, "sub7_5", w);
    check("first_grant_wait", 64'(w), 64'd0);
    collect(0, "sub7_5");

    // Contention: req0 add 3+4 wins, then req1 SLT -1<2
    drive_req(1'b0, 32'd3, 32'd4, OP_ADD);
    drive_req(1'b1, 32'hFFFF_FFFF, 32'd2, OP_SLT);
    accept(1'b0, "rr_add", w);
    collect(0, "rr_add");
    accept(1'b1, "rr_slt", w);
    collect(0, "rr_slt");

    // Next simultaneous pair: req1 goes first
    drive_req(1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND);
    drive_req(1'b1, 32'h0000_0A00, 32'h0000_00B0, OP_OR);
    accept(1'b1, "rr2_or", w);
    collect(0, "rr2_or");
    accept(1'b0, "rr2_and", w);
    collect(0, "rr2_and");

    // Zero flag: 5-5 and undefined code 110
    drive_req(1'b0, 32'd5, 32'd5, OP_SUB);
    accept(1'b0, "zero_sub", w);
    collect(0, "zero_sub");
    drive_req(1'b1, 32'd9, 32'd9, 3'b110);
    accept(1'b1, "zero_undef", w);
    collect(0, "zero_undef");

    // Backpressure on rsp1 for 10 cycles with req0 waiting
    drive_req(1'b1, 32'd10, 32'd20, OP_ADD);
    accept(1'b1, "bp_add", w);
    drive_req(1'b0, 32'd100, 32'd1, OP_SUB);
    collect(10, "bp_add");
    accept(1'b0, "bp_after", w);
    collect(0, "bp_after");

    // rsp_ready while no response pending has no effect
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_ready op_count", 64'(op_count), 64'(exp_cnt));
    check("stray_ready rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset while in RESP discards the operation
    drive_req(1'b0, 32'd1, 32'd1, OP_ADD);
    accept(1'b0, "rst_mid", w);
    void'(sb.pop_back());
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_mid op_count", 64'(op_count), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid result", 64'(rsp0_result), 64'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst no_rsp", 64'({rsp0_valid, rsp1_valid, busy}), 64'd0);
    end

    // Counter wrap over 16 handshakes; last is 0x7FFFFFFF+1
    for (int i = 0; i < 15; i++) begin
      drive_req(1'(i % 2), $urandom, $urandom, 3'($urandom_range(0, 7)));
      accept(1'(i % 2), "wrap_fill", w);
      collect(0, "wrap_fill");
    end
    check("wrap pre_count", 64'(op_count), 64'd15);
    drive_req(1'b0, 32'h7FFF_FFFF, 32'd1, OP_ADD);
    accept(1'b0, "ovf_add", w);
    collect(0, "ovf_add");
    check("wrap op_count", 64'(op_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
